// File: rtl/vga_timing_ctrl.sv
// VGA 640x480@60 scan timing: counters, sync decode, one-cycle-early pixel request and blanked RGB.
// Optional frame counter and frame-start pulse are built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_ctrl #(
  parameter logic [9:0] H_SYNC   = 10'd96,
  parameter logic [9:0] H_BACK   = 10'd40,
  parameter logic [9:0] H_LEFT   = 10'd8,
  parameter logic [9:0] H_VALID  = 10'd640,
  parameter logic [9:0] H_RIGHT  = 10'd8,
  parameter logic [9:0] H_FRONT  = 10'd8,
  parameter logic [9:0] V_SYNC   = 10'd2,
  parameter logic [9:0] V_BACK   = 10'd25,
  parameter logic [9:0] V_TOP    = 10'd8,
  parameter logic [9:0] V_VALID  = 10'd480,
  parameter logic [9:0] V_BOTTOM = 10'd8,
  parameter logic [9:0] V_FRONT  = 10'd2,
  parameter logic       SYNC_ACT = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        frame_start
`endif
);

  localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam logic [9:0] H_MAX   = H_TOTAL - 10'd1;
  localparam logic [9:0] V_MAX   = V_TOTAL - 10'd1;
  localparam logic [9:0] HS0     = H_SYNC + H_BACK + H_LEFT;
  localparam logic [9:0] HE0     = HS0 + H_VALID;
  localparam logic [9:0] VS0     = V_SYNC + V_BACK + V_TOP;
  localparam logic [9:0] VE0     = VS0 + V_VALID;
  // Request window sits one column ahead of the visible window.
  localparam logic [9:0] REQ_S   = HS0 - 10'd1;
  localparam logic [9:0] REQ_E   = HE0 - 10'd1;
  localparam logic [9:0] NO_REQ  = 10'h3FF;

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       h_end, v_end, frame_end;
  logic       row_valid, rgb_valid, pix_data_req;

  always_comb begin
    h_end     = (cnt_h_q == H_MAX);
    v_end     = (cnt_v_q == V_MAX);
    frame_end = h_end && v_end;
    cnt_h_d   = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d   = cnt_v_q;
    if (h_end) begin
      cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  always_comb begin
    hsync        = (cnt_h_q < H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    vsync        = (cnt_v_q < V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    row_valid    = (cnt_v_q >= VS0) && (cnt_v_q < VE0);
    rgb_valid    = row_valid && (cnt_h_q >= HS0) && (cnt_h_q < HE0);
    pix_data_req = row_valid && (cnt_h_q >= REQ_S) && (cnt_h_q < REQ_E);
    pix_x        = pix_data_req ? cnt_h_q - REQ_S : NO_REQ;
    pix_y        = pix_data_req ? cnt_v_q - VS0 : NO_REQ;
    rgb          = rgb_valid ? pix_data : 16'h0000;
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;

  // Registering frame_end lands the pulse on the origin cycle, but not on the one after reset.
  always_comb begin
    frame_cnt_d   = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    frame_start_d = frame_end;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_q   <= 16'd0;
      frame_start_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign frame_start = frame_start_q;
`endif

endmodule
